// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with tree-PLRU replacement,
// combinational lookup and same-cycle write bypass.
module btb_assoc #(
   parameter int S_INDEX = 3,
   parameter int WAYS    = 2,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lookup_valid,
   input  logic [WIDTH-1:0] lookup_pc,
   output logic             hit,
   output logic [WIDTH-1:0] target,
   input  logic             update,
   input  logic [WIDTH-1:0] update_pc,
   input  logic [WIDTH-1:0] update_target,
   input  logic             invalidate
);
   localparam int SETS = 1 << S_INDEX;
   localparam int WW   = (WAYS == 4) ? 2 : 1;
   localparam int TW   = WIDTH - S_INDEX - 2;

   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-2:0]  plru_q  [SETS];
   logic [TW-1:0]    tag_q   [SETS][WAYS];
   logic [WIDTH-1:0] tgt_q   [SETS][WAYS];

   logic [S_INDEX-1:0] l_idx, u_idx;
   logic [TW-1:0]      l_tag, u_tag;
   logic               l_hit, u_hit, u_free, upd_en, byp;
   logic [WW-1:0]      l_way, u_match, u_free_way, u_way;
   logic [WIDTH-1:0]   l_tgt;
   logic [2:0]         lk3, up3;
   logic [WAYS-2:0]    lk_plru_d, up_plru_d;
   logic               unused_pc_lsbs;

   // Bits are b0 (pair select), b1 (within ways 0/1), b2 (within ways 2/3).
   function automatic logic [1:0] victim(input logic [2:0] p);
      return (WAYS == 2) ? {1'b0, p[0]} : (p[0] ? {1'b1, p[2]} : {1'b0, p[1]});
   endfunction

   function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
      return (WAYS == 2) ? {p[2:1], ~w[0]} : (w[1] ? {~w[0], p[1], 1'b0} : {p[2], ~w[0], 1'b1});
   endfunction

   assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};
   assign l_idx  = lookup_pc[S_INDEX+1:2];
   assign l_tag  = lookup_pc[WIDTH-1:S_INDEX+2];
   assign u_idx  = update_pc[S_INDEX+1:2];
   assign u_tag  = update_pc[WIDTH-1:S_INDEX+2];
   assign upd_en = update && !invalidate && !rst;
   assign byp    = upd_en && u_idx == l_idx && u_tag == l_tag;
   assign hit    = !rst && (l_hit || byp);
   assign target = !hit ? '0 : byp ? update_target : l_tgt;

   always_comb begin
      l_hit      = 1'b0;
      l_way      = '0;
      l_tgt      = '0;
      u_hit      = 1'b0;
      u_match    = '0;
      u_free     = 1'b0;
      u_free_way = '0;
      // Descending scan so the lowest-numbered invalid way is the one kept.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
            l_hit = 1'b1;
            l_way = WW'(w);
            l_tgt = tgt_q[l_idx][w];
         end
         if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
            u_hit   = 1'b1;
            u_match = WW'(w);
         end
         if (!valid_q[u_idx][w]) begin
            u_free     = 1'b1;
            u_free_way = WW'(w);
         end
      end
      u_way     = u_hit ? u_match : u_free ? u_free_way : WW'(victim(3'(plru_q[u_idx])));
      lk3       = touch(3'(plru_q[l_idx]), 2'(l_way));
      up3       = touch(3'(plru_q[u_idx]), 2'(u_way));
      lk_plru_d = lk3[WAYS-2:0];
      up_plru_d = up3[WAYS-2:0];
   end

   // The update touch is applied last so it wins on a shared set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || invalidate) begin
         for (int i = 0; i < SETS; i++) begin
            valid_q[i] <= '0;
            plru_q[i]  <= '0;
         end
      end else begin
         if (lookup_valid && l_hit) plru_q[l_idx] <= lk_plru_d;
         if (update) begin
            valid_q[u_idx][u_way] <= 1'b1;
            plru_q[u_idx]         <= up_plru_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (upd_en) begin
         tag_q[u_idx][u_way] <= u_tag;
         tgt_q[u_idx][u_way] <= update_target;
      end
   end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: table-driven directed check of btb_assoc (S_INDEX=3, WAYS=2, WIDTH=32).
module tb_btb_assoc;
   logic        clk = 1'b0;
   logic        rst, lookup_valid, update, invalidate, hit;
   logic [31:0] lookup_pc, update_pc, update_target, target;

   typedef struct {
      logic        rst;
      logic        lv;
      logic [31:0] lpc;
      logic        upd;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic        inv;
      logic        ehit;
      logic [31:0] etgt;
   } vec_t;

   vec_t vq[$];
   int   applied = 0;
   int   miscompares = 0;

   btb_assoc #(.S_INDEX(3), .WAYS(2), .WIDTH(32)) dut (
      .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .hit(hit), .target(target), .update(update), .update_pc(update_pc),
      .update_target(update_target), .invalidate(invalidate)
   );

   always #5 clk = ~clk;

   task automatic v(input logic r, input logic lv, input logic [31:0] lpc, input logic upd,
                    input logic [31:0] upc, input logic [31:0] utgt, input logic inv,
                    input logic eh, input logic [31:0] et);
      vec_t x;
      x.rst = r; x.lv = lv; x.lpc = lpc; x.upd = upd; x.upc = upc;
      x.utgt = utgt; x.inv = inv; x.ehit = eh; x.etgt = et;
      vq.push_back(x);
   endtask

   task automatic check(input string name, input logic eh, input logic [31:0] et);
      applied++;
      if (hit !== eh || target !== et) begin
         miscompares++;
         $display("FAIL %s: got hit=%0b target=%h, want hit=%0b target=%h", name, hit, target, eh, et);
      end
   endtask

   initial begin
      rst = 1'b1; lookup_valid = 1'b0; update = 1'b0; invalidate = 1'b0;
      lookup_pc = '0; update_pc = '0; update_target = '0;
      // reset, write and bypass
      v(1,0,32'h40, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h40, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h40, 1,32'h40,32'h100, 0, 1,32'h100);
      v(0,0,32'h40, 0,0,0, 0, 1,32'h100);
      // replacement: hit on 0x40 moves the victim to 0x80
      v(0,0,32'h80, 1,32'h80,32'h200, 0, 1,32'h200);
      v(0,1,32'h40, 0,0,0, 0, 1,32'h100);
      v(0,0,32'hC0, 1,32'hC0,32'h300, 0, 1,32'h300);
      v(0,0,32'h80, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h40, 0,0,0, 0, 1,32'h100);
      v(0,0,32'hC0, 0,0,0, 0, 1,32'h300);
      // invalidate takes effect at the edge only
      v(0,0,32'h40, 0,0,0, 1, 1,32'h100);
      v(0,0,32'h40, 0,0,0, 0, 0,32'h0);
      // re-update keeps the other way
      v(0,0,32'h0,  1,32'h40,32'h100, 0, 0,32'h0);
      v(0,0,32'h40, 1,32'h80,32'h200, 0, 1,32'h100);
      v(0,0,32'h40, 1,32'h40,32'h500, 0, 1,32'h500);
      v(0,0,32'h40, 0,0,0, 0, 1,32'h500);
      v(0,0,32'h80, 0,0,0, 0, 1,32'h200);
      // flush collision
      v(0,0,32'h40, 0,0,0, 1, 1,32'h500);
      v(0,0,32'h80, 1,32'h40,32'h111, 0, 0,32'h0);
      v(0,0,32'h80, 1,32'h80,32'h200, 1, 0,32'h0);
      v(0,0,32'h40, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h80, 0,0,0, 0, 0,32'h0);
      // lookups with lookup_valid=0 leave PLRU alone
      v(0,0,32'h0,  1,32'h40,32'h100, 0, 0,32'h0);
      v(0,0,32'h40, 1,32'h80,32'h200, 0, 1,32'h100);
      v(0,0,32'h40, 1,32'hC0,32'h300, 0, 1,32'h100);
      v(0,0,32'h40, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h80, 0,0,0, 0, 1,32'h200);
      // other set, pc[1:0] ignored
      v(0,0,32'h44, 1,32'h44,32'h444, 0, 1,32'h444);
      v(0,0,32'h46, 0,0,0, 0, 1,32'h444);
      v(0,0,32'hC0, 0,0,0, 0, 1,32'h300);
      // update ignored under reset
      v(1,0,32'h48, 1,32'h48,32'h1, 0, 0,32'h0);
      v(0,0,32'h44, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h48, 0,0,0, 0, 0,32'h0);
      // update touch beats lookup touch in the same set
      v(0,0,32'h0,  1,32'h40,32'h100, 0, 0,32'h0);
      v(0,0,32'h0,  1,32'h80,32'h200, 0, 0,32'h0);
      v(0,1,32'h80, 1,32'h40,32'h101, 0, 1,32'h200);
      v(0,0,32'h40, 1,32'hC0,32'h300, 0, 1,32'h101);
      v(0,0,32'h80, 0,0,0, 0, 0,32'h0);
      v(0,0,32'h40, 0,0,0, 0, 1,32'h101);
      v(0,0,32'hC0, 0,0,0, 0, 1,32'h300);

      foreach (vq[i]) begin
         @(negedge clk);
         rst = vq[i].rst; lookup_valid = vq[i].lv; lookup_pc = vq[i].lpc;
         update = vq[i].upd; update_pc = vq[i].upc; update_target = vq[i].utgt;
         invalidate = vq[i].inv;
         #1 check($sformatf("vec%0d", i), vq[i].ehit, vq[i].etgt);
      end

      // async reset drops hit before the next rising edge
      @(negedge clk);
      rst = 1'b0; lookup_valid = 1'b0; invalidate = 1'b0;
      update = 1'b1; update_pc = 32'h40; update_target = 32'h100; lookup_pc = 32'h0;
      @(negedge clk);
      update = 1'b0; lookup_pc = 32'h40;
      #1 check("async_pre", 1'b1, 32'h100);
      #1 rst = 1'b1;
      #1 check("async_rst", 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("async_after", 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning log2 of set count.
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; legal values are 2 and 4 only.
REQ-003 SHALL have parameter WIDTH, default 32, meaning PC and target width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port lookup_valid  input  1  the fetch lookup is real, so replacement state may be touched.
REQ-007 SHALL have port lookup_pc  input  WIDTH  the fetch PC to look up.
REQ-008 SHALL have port hit  output  1  lookup_pc is resident.
REQ-009 SHALL have port target  output  WIDTH  the predicted target, '0 when hit=0.
REQ-010 SHALL have port update  input  1  write a resolved branch.
REQ-011 SHALL have port update_pc  input  WIDTH  the branch PC being written.
REQ-012 SHALL have port update_target  input  WIDTH  the branch target being written.
REQ-013 SHALL have port invalidate  input  1  flush all entries.

Function
REQ-014 SHALL derive index = pc[S_INDEX+1:2] and tag = pc[WIDTH-1:S_INDEX+2] for both lookup_pc and update_pc; pc[1:0] are ignored.
REQ-015 SHALL store valid, tag and target for each of 2**S_INDEX sets x WAYS ways.
REQ-016 SHALL resolve lookups combinationally in the same cycle: hit=1 when any valid way in the set matches the tag; target is that way's data.
REQ-017 SHALL bypass a same-cycle write: when update=1, invalidate=0, and update_pc index and tag equal lookup_pc's, it SHALL drive hit=1 and target=update_target.
REQ-018 SHALL, on update with a tag match in the set, overwrite that way's target at the next edge and allocate no other way.
REQ-019 SHALL, on update with no tag match, write the lowest-numbered invalid way, else the PLRU victim, setting valid=1 and the tag.
REQ-020 SHALL keep tree-PLRU state of WAYS-1 bits per set. WAYS=2: the bit names the victim way. WAYS=4: b0=0 picks the victim from {0,1}, else {2,3}; b1 picks within {0,1} (0 gives way0); b2 picks within {2,3} (0 gives way2).
REQ-021 SHALL, when way w is touched, set the PLRU bits on w's path to point away from w.
REQ-022 SHALL touch PLRU on a lookup hit with lookup_valid=1, and on every update for the written way.
REQ-023 SHALL let the update touch win when a lookup touch and an update target the same set in one cycle.
REQ-024 SHALL, on invalidate=1, clear all valid bits and all PLRU bits at the next edge.
REQ-025 SHALL drop an update and suppress the bypass when invalidate and update are asserted in the same cycle.
REQ-026 SHALL leave tags and targets unchanged on invalidate; they need no reset.

Reset
REQ-027 SHALL, while rst=1 and with no clock edge needed, clear all valid bits and PLRU bits, giving hit=0 and target='0.
REQ-028 SHALL ignore update, invalidate and lookup_valid while rst=1.
REQ-029 SHALL, when rst is asserted mid-operation between edges, drop hit to 0 in the same cycle for every lookup_pc.

Verification
(S_INDEX=3, WAYS=2, WIDTH=32.)
REQ-030 SHALL cover reset: pulse rst, then look up 0x40 -> hit=0, target=0x0.
REQ-031 SHALL cover write and bypass: update 0x40 to target 0x100 -> the same-cycle lookup of 0x40 gives hit=1, target=0x100; the lookup in the next cycle also gives hit=1, target=0x100.
REQ-032 SHALL cover replacement: update 0x40 to 0x100, update 0x80 to 0x200, look up 0x40 with lookup_valid=1, update 0xC0 to 0x300 -> 0x80 misses; 0x40 hits with 0x100; 0xC0 hits with 0x300.
REQ-033 SHALL cover re-update: update 0x40 to 0x100, update 0x80 to 0x200, update 0x40 to 0x500 -> 0x40 hits with 0x500 and 0x80 still hits with 0x200.
REQ-034 SHALL cover flush collision: fill 0x40, then assert invalidate and update 0x80 to 0x200 together -> the same-cycle lookup of 0x80 misses; the next cycle 0x40 and 0x80 both miss.
REQ-035 SHALL cover async reset: fill 0x40, then assert rst mid-cycle -> hit falls to 0 before the next rising edge.
